// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//
// Decode-to-execute pipeline register for the 64-bit LEGv8 datapath. It
// captures the register-file read data, decoded immediate, destination index
// and packed control bundle every cycle. The hazard unit can stall (hold) or
// flush (insert a bubble). A writeback bypass makes sure an operand read in
// the same cycle as a regfile write, or held across a stall while the
// producer retires, is never stale.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall, flush      hazard-unit controls (flush wins over stall)
//   valid_d, pc_d     decode slot valid / PC
//   ra1_d, ra2_d      source register indices driven to the regfile
//   rd1_d, rd2_d      regfile read data
//   wa_d, imm_d       destination index, sign-extended immediate
//   ctrl_d            packed control bundle
//   wb_we/wb_wa/wb_wd writeback port (same as regfile we3/wa3/wd3)
//   *_e               registered execute-stage copies of the above
//   stall_cnt         saturating count of stalled cycles holding a valid op
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int          N      = 64,
  parameter int          CTRL_W = 16,
  parameter logic [4:0]  ZR     = 5'd31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_d,
  input  logic [N-1:0]      pc_d,
  input  logic [4:0]        ra1_d,
  input  logic [4:0]        ra2_d,
  input  logic [N-1:0]      rd1_d,
  input  logic [N-1:0]      rd2_d,
  input  logic [4:0]        wa_d,
  input  logic [N-1:0]      imm_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              wb_we,
  input  logic [4:0]        wb_wa,
  input  logic [N-1:0]      wb_wd,
  output logic              valid_e,
  output logic [N-1:0]      pc_e,
  output logic [N-1:0]      rd1_e,
  output logic [N-1:0]      rd2_e,
  output logic [N-1:0]      imm_e,
  output logic [4:0]        ra1_e,
  output logic [4:0]        ra2_e,
  output logic [4:0]        wa_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [15:0]       stall_cnt
);

  // Operand captured on a normal load: XZR always reads as zero, otherwise
  // a same-cycle writeback to the source register takes precedence over the
  // (old) regfile read data.
  function automatic logic [N-1:0] load_operand(
    input logic [4:0]   ra,
    input logic [N-1:0] rd,
    input logic         we,
    input logic [4:0]   wa,
    input logic [N-1:0] wd
  );
    if (ra == ZR)
      return '0;
    else if (we && (wa == ra))
      return wd;
    else
      return rd;
  endfunction

  // Operand during a stall: keep the held value unless the producer of the
  // held source register retires this cycle.
  function automatic logic [N-1:0] hold_operand(
    input logic [4:0]   ra_held,
    input logic [N-1:0] rd_held,
    input logic         we,
    input logic [4:0]   wa,
    input logic [N-1:0] wd
  );
    if (we && (wa != ZR) && (wa == ra_held))
      return wd;
    else
      return rd_held;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic              r_valid_e;
  logic [N-1:0]      r_pc_e;
  logic [N-1:0]      r_rd1_e;
  logic [N-1:0]      r_rd2_e;
  logic [N-1:0]      r_imm_e;
  logic [4:0]        r_ra1_e;
  logic [4:0]        r_ra2_e;
  logic [4:0]        r_wa_e;
  logic [CTRL_W-1:0] r_ctrl_e;
  logic [15:0]       r_stall_cnt;

  logic [N-1:0]      w_rd1_load;
  logic [N-1:0]      w_rd2_load;
  logic [N-1:0]      w_rd1_hold;
  logic [N-1:0]      w_rd2_hold;

  assign w_rd1_load = load_operand(ra1_d, rd1_d, wb_we, wb_wa, wb_wd);
  assign w_rd2_load = load_operand(ra2_d, rd2_d, wb_we, wb_wa, wb_wd);
  assign w_rd1_hold = hold_operand(r_ra1_e, r_rd1_e, wb_we, wb_wa, wb_wd);
  assign w_rd2_hold = hold_operand(r_ra2_e, r_rd2_e, wb_we, wb_wa, wb_wd);

  // ---- decode -> execute boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid_e   <= 1'b0;
      r_pc_e      <= '0;
      r_rd1_e     <= '0;
      r_rd2_e     <= '0;
      r_imm_e     <= '0;
      r_ra1_e     <= ZR;
      r_ra2_e     <= ZR;
      r_wa_e      <= ZR;
      r_ctrl_e    <= '0;
      r_stall_cnt <= '0;
    end else if (flush) begin
      // Bubble: kill valid/control/destination; the data fields simply load
      // so the datapath mux stays shared with the normal load path.
      r_valid_e   <= 1'b0;
      r_pc_e      <= pc_d;
      r_rd1_e     <= w_rd1_load;
      r_rd2_e     <= w_rd2_load;
      r_imm_e     <= imm_d;
      r_ra1_e     <= ra1_d;
      r_ra2_e     <= ra2_d;
      r_wa_e      <= ZR;
      r_ctrl_e    <= '0;
    end else if (stall) begin
      r_rd1_e <= w_rd1_hold;
      r_rd2_e <= w_rd2_hold;
      if (r_valid_e)
        r_stall_cnt <= sat_inc16(r_stall_cnt);
    end else begin
      r_valid_e   <= valid_d;
      r_pc_e      <= pc_d;
      r_rd1_e     <= w_rd1_load;
      r_rd2_e     <= w_rd2_load;
      r_imm_e     <= imm_d;
      r_ra1_e     <= ra1_d;
      r_ra2_e     <= ra2_d;
      r_wa_e      <= wa_d;
      r_ctrl_e    <= ctrl_d;
    end
  end

  assign valid_e   = r_valid_e;
  assign pc_e      = r_pc_e;
  assign rd1_e     = r_rd1_e;
  assign rd2_e     = r_rd2_e;
  assign imm_e     = r_imm_e;
  assign ra1_e     = r_ra1_e;
  assign ra2_e     = r_ra2_e;
  assign wa_e      = r_wa_e;
  assign ctrl_e    = r_ctrl_e;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Directed bench for id_ex_stage_reg. Each step drives decode/control inputs,
// pushes the hand-derived expected execute-stage contents to a queue, and
// after the clock edge pops the entry and compares it with the outputs.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  localparam int N      = 64;
  localparam int CTRL_W = 16;

  typedef struct {
    logic              valid;
    logic [N-1:0]      pc;
    logic [N-1:0]      rd1;
    logic [N-1:0]      rd2;
    logic [N-1:0]      imm;
    logic [4:0]        ra1;
    logic [4:0]        ra2;
    logic [4:0]        wa;
    logic [CTRL_W-1:0] ctrl;
    logic [15:0]       cnt;
    logic              chk_data;  // 0 when data fields are don't-care
  } exp_t;

  logic              clk = 1'b0;
  logic              reset, stall, flush, valid_d;
  logic [N-1:0]      pc_d, rd1_d, rd2_d, imm_d, wb_wd;
  logic [4:0]        ra1_d, ra2_d, wa_d, wb_wa;
  logic [CTRL_W-1:0] ctrl_d;
  logic              wb_we;
  logic              valid_e;
  logic [N-1:0]      pc_e, rd1_e, rd2_e, imm_e;
  logic [4:0]        ra1_e, ra2_e, wa_e;
  logic [CTRL_W-1:0] ctrl_e;
  logic [15:0]       stall_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  id_ex_stage_reg #(.N(N), .CTRL_W(CTRL_W), .ZR(5'd31)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_d(valid_d), .pc_d(pc_d), .ra1_d(ra1_d), .ra2_d(ra2_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .wa_d(wa_d), .imm_d(imm_d),
    .ctrl_d(ctrl_d), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .valid_e(valid_e), .pc_e(pc_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
    .imm_e(imm_e), .ra1_e(ra1_e), .ra2_e(ra2_e), .wa_e(wa_e),
    .ctrl_e(ctrl_e), .stall_cnt(stall_cnt)
  );

  function automatic exp_t mk(input logic v, input logic [N-1:0] pc,
                              input logic [N-1:0] r1, input logic [N-1:0] r2,
                              input logic [N-1:0] im, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [4:0] w,
                              input logic [CTRL_W-1:0] c, input logic [15:0] n,
                              input logic cd);
    exp_t e;
    e.valid = v; e.pc = pc; e.rd1 = r1; e.rd2 = r2; e.imm = im;
    e.ra1 = a1; e.ra2 = a2; e.wa = w; e.ctrl = c; e.cnt = n; e.chk_data = cd;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic compare(input string step_name, input exp_t e);
    chk({step_name, ".valid_e"},   N'(valid_e),   N'(e.valid));
    chk({step_name, ".ctrl_e"},    N'(ctrl_e),    N'(e.ctrl));
    chk({step_name, ".wa_e"},      N'(wa_e),      N'(e.wa));
    chk({step_name, ".stall_cnt"}, N'(stall_cnt), N'(e.cnt));
    if (e.chk_data) begin
      chk({step_name, ".pc_e"},  pc_e,       e.pc);
      chk({step_name, ".rd1_e"}, rd1_e,      e.rd1);
      chk({step_name, ".rd2_e"}, rd2_e,      e.rd2);
      chk({step_name, ".imm_e"}, imm_e,      e.imm);
      chk({step_name, ".ra1_e"}, N'(ra1_e),  N'(e.ra1));
      chk({step_name, ".ra2_e"}, N'(ra2_e),  N'(e.ra2));
    end
  endtask

  // Inputs are already driven; queue the expectation, clock, then check.
  task automatic step(input string step_name, input exp_t e);
    exp_t got;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", step_name);
    end else begin
      got = sb.pop_front();
      compare(step_name, got);
    end
  endtask

  task automatic set_dec(input logic v, input logic [N-1:0] pc,
                         input logic [4:0] a1, input logic [N-1:0] r1,
                         input logic [4:0] a2, input logic [N-1:0] r2,
                         input logic [4:0] w, input logic [N-1:0] im,
                         input logic [CTRL_W-1:0] c);
    valid_d = v; pc_d = pc; ra1_d = a1; rd1_d = r1; ra2_d = a2; rd2_d = r2;
    wa_d = w; imm_d = im; ctrl_d = c;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] wa, input logic [N-1:0] wd);
    wb_we = we; wb_wa = wa; wb_wd = wd;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    // Reset with arbitrary non-zero decode/writeback inputs
    set_dec(1'b1, 64'hCAFE, 5'd3, 64'h1111, 5'd4, 64'h2222, 5'd5, 64'h3333, 16'h7777);
    set_wb(1'b1, 5'd3, 64'h4444);
    step("reset1", mk(0, 0, 0, 0, 0, 31, 31, 31, 0, 0, 1));
    step("reset2", mk(0, 0, 0, 0, 0, 31, 31, 31, 0, 0, 1));

    // Plain load
    reset = 1'b0;
    set_dec(1'b1, 64'h100, 5'd10, 64'h1234, 5'd11, 64'h5, 5'd3, 64'h20, 16'hA5A5);
    set_wb(1'b0, 5'd10, 64'hDEAD);
    step("load", mk(1, 64'h100, 64'h1234, 64'h5, 64'h20, 10, 11, 3, 16'hA5A5, 0, 1));

    // Same-cycle bypass on source 1 only
    set_dec(1'b1, 64'h104, 5'd10, 64'h0, 5'd11, 64'h77, 5'd4, 64'hFFFF_FFFF_FFFF_FFF8, 16'h0F0F);
    set_wb(1'b1, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF);
    step("bypass1", mk(1, 64'h104, 64'hFFFF_FFFF_FFFF_FFFF, 64'h77,
                       64'hFFFF_FFFF_FFFF_FFF8, 10, 11, 4, 16'h0F0F, 0, 1));

    // Both sources match the writeback address
    set_dec(1'b1, 64'h108, 5'd7, 64'h1, 5'd7, 64'h2, 5'd5, 64'h1, 16'h0001);
    set_wb(1'b1, 5'd7, 64'h55);
    step("bypass_both", mk(1, 64'h108, 64'h55, 64'h55, 64'h1, 7, 7, 5, 16'h0001, 0, 1));

    // Zero register reads as zero even when written back
    set_dec(1'b1, 64'h10C, 5'd31, 64'hDEAD, 5'd31, 64'hBEEF, 5'd6, 64'h2, 16'h0002);
    set_wb(1'b1, 5'd31, 64'h999);
    step("xzr", mk(1, 64'h10C, 64'h0, 64'h0, 64'h2, 31, 31, 6, 16'h0002, 0, 1));

    // Bypass still applies to an invalid decode slot
    set_dec(1'b0, 64'h110, 5'd2, 64'h1, 5'd3, 64'h33, 5'd7, 64'h3, 16'h0003);
    set_wb(1'b1, 5'd2, 64'h42);
    step("bypass_invalid", mk(0, 64'h110, 64'h42, 64'h33, 64'h3, 2, 3, 7, 16'h0003, 0, 1));

    // Load ra2=5/rd2=7 then stall three cycles
    set_dec(1'b1, 64'h200, 5'd6, 64'h61, 5'd5, 64'h7, 5'd9, 64'h10, 16'h1234);
    set_wb(1'b0, 5'd0, 64'h0);
    step("pre_stall", mk(1, 64'h200, 64'h61, 64'h7, 64'h10, 6, 5, 9, 16'h1234, 0, 1));

    stall = 1'b1;
    set_dec(1'b0, 64'h999, 5'd1, 64'hAAAA, 5'd8, 64'hBBBB, 5'd1, 64'h0, 16'hFFFF);
    set_wb(1'b0, 5'd5, 64'h1);
    step("stall1", mk(1, 64'h200, 64'h61, 64'h7, 64'h10, 6, 5, 9, 16'h1234, 1, 1));
    set_wb(1'b1, 5'd5, 64'd99);
    step("stall2_refresh", mk(1, 64'h200, 64'h61, 64'd99, 64'h10, 6, 5, 9, 16'h1234, 2, 1));
    // Writeback to the destination index (not a held source) changes nothing
    set_wb(1'b1, 5'd9, 64'hBAD);
    step("stall3", mk(1, 64'h200, 64'h61, 64'd99, 64'h10, 6, 5, 9, 16'h1234, 3, 1));

    // Flush overrides a simultaneous stall
    flush = 1'b1;
    set_dec(1'b1, 64'h300, 5'd12, 64'hC, 5'd13, 64'hD, 5'd14, 64'h30, 16'hFFFF);
    set_wb(1'b0, 5'd0, 64'h0);
    step("flush_stall", mk(0, 0, 0, 0, 0, 0, 0, 31, 16'h0, 3, 0));

    // Next decode loads normally
    flush = 1'b0; stall = 1'b0;
    set_dec(1'b1, 64'h304, 5'd12, 64'hC1, 5'd13, 64'hD1, 5'd14, 64'h31, 16'h00F0);
    step("after_flush", mk(1, 64'h304, 64'hC1, 64'hD1, 64'h31, 12, 13, 14, 16'h00F0, 3, 1));

    // Flush alone, then a stall with valid_e=0 must not count
    flush = 1'b1;
    step("flush_only", mk(0, 0, 0, 0, 0, 0, 0, 31, 16'h0, 3, 0));
    flush = 1'b0; stall = 1'b1;
    step("stall_bubble", mk(0, 0, 0, 0, 0, 0, 0, 31, 16'h0, 3, 0));

    // Reset in the middle of a stall
    reset = 1'b1;
    step("reset_mid_stall", mk(0, 0, 0, 0, 0, 31, 31, 31, 0, 0, 1));

    // Saturation of stall_cnt
    reset = 1'b0; stall = 1'b0;
    set_dec(1'b1, 64'h400, 5'd1, 64'h11, 5'd2, 64'h22, 5'd3, 64'h44, 16'h0404);
    step("sat_load", mk(1, 64'h400, 64'h11, 64'h22, 64'h44, 1, 2, 3, 16'h0404, 0, 1));
    stall = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    step("sat_hold", mk(1, 64'h400, 64'h11, 64'h22, 64'h44, 1, 2, 3, 16'h0404, 16'hFFFF, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Decode-to-execute pipeline register for the 64-bit LEGv8 datapath.
- Sits directly downstream of the register file: it captures the regfile read ports (rd1/rd2) plus decoded immediate, destination and control each cycle.
- Provides stall (hold) and flush (bubble) control for the hazard unit.
- Applies a writeback bypass so operands captured in the same cycle as a regfile write, or held during a stall, are never stale.

Parameters:
- N, 64, datapath width.
- CTRL_W, 16, width of the packed control bundle.
- ZR, 31, index of the zero register (XZR); never bypassed.

Ports:
- clk  in  1  clock, rising edge active
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all stage contents this cycle
- flush  in  1  replace stage contents with a bubble this cycle
- valid_d  in  1  decode slot holds a real instruction
- pc_d  in  N  decode PC
- ra1_d, ra2_d  in  5 each  source register indices (as driven to the regfile)
- rd1_d, rd2_d  in  N each  regfile read data
- wa_d  in  5  destination register index
- imm_d  in  N  sign-extended immediate
- ctrl_d  in  CTRL_W  control bundle
- wb_we  in  1  writeback write enable (same signal as regfile we3)
- wb_wa  in  5  writeback address (regfile wa3)
- wb_wd  in  N  writeback data (regfile wd3)
- valid_e  out  1  execute slot valid
- pc_e, rd1_e, rd2_e, imm_e  out  N each
- ra1_e, ra2_e, wa_e  out  5 each
- ctrl_e  out  CTRL_W
- stall_cnt  out  16  saturating count of stalled cycles with valid_e=1

Behaviour:
- All outputs are registered and update only on the rising edge of clk. Latency from decode inputs to execute outputs is 1 cycle.
- Reset (synchronous, highest priority):
  - valid_e=0; ctrl_e=0; pc_e, rd1_e, rd2_e and imm_e = 0.
  - ra1_e, ra2_e and wa_e = ZR.
  - stall_cnt=0.
- Priority per edge: reset > flush > stall > load.
- Flush:
  - valid_e=0, ctrl_e=0, wa_e=ZR.
  - Other data fields are don't-care; the implementation loads them normally.
  - Flush overrides a simultaneous stall.
- Stall (no flush):
  - All fields hold.
  - Exception: held operands are refreshed from writeback when wb_we=1, wb_wa!=ZR and wb_wa==ra1_e (rd1_e<=wb_wd), and likewise for ra2_e/rd2_e.
  - If valid_e=1, stall_cnt increments, saturating at 16'hFFFF.
- Load (no stall, no flush):
  - All *_e <= *_d, with valid_e <= valid_d.
  - Bypass: rd1_e <= wb_wd if wb_we=1, wb_wa==ra1_d and ra1_d!=ZR; otherwise rd1_e <= rd1_d. Same rule for rd2.
  - If ra1_d==ZR, rd1_e <= 0 regardless of rd1_d. Same rule for rd2.
- Both sources may match wb_wa simultaneously; both are bypassed.
- Bypass applies even when valid_d=0. It is harmless and keeps the logic uniform.
- stall_cnt never clears except on reset. It does not change on flush or load cycles.
- Reset asserted mid-stall or mid-flush takes effect on that edge and discards the instruction.

Test Plan:
- Reset: hold reset 2 cycles with arbitrary inputs -> valid_e=0, ctrl_e=0, rd1_e=0, wa_e=31, stall_cnt=0.
- Plain load: valid_d=1, ra1_d=10, rd1_d=64'h1234, ra2_d=11, rd2_d=64'h5, wb_we=0 -> next edge: rd1_e=64'h1234, rd2_e=5, valid_e=1.
- Same-cycle bypass: ra1_d=10, rd1_d=0, wb_we=1, wb_wa=10, wb_wd=64'hFFFF_FFFF_FFFF_FFFF -> rd1_e=64'hFFFF_FFFF_FFFF_FFFF; rd2_e (ra2_d=11) is unchanged from rd2_d.
- Zero register: ra1_d=31, rd1_d=64'hDEAD, wb_we=1, wb_wa=31 -> rd1_e=0.
- Stall with refresh:
  - Load ra2_d=5, rd2_d=7; then stall for 3 cycles.
  - In stall cycle 2, drive wb_we=1, wb_wa=5, wb_wd=99.
  - Required: rd2_e=99 from that edge on; all other fields unchanged; stall_cnt=3.
- Flush vs stall: valid_e=1, then assert stall=1 and flush=1 together -> valid_e=0, ctrl_e=0, wa_e=31, stall_cnt unchanged; next cycle with both deasserted, the new decode contents load normally.
